// File: rtl/alien_march_ctrl.sv
// alien_march_ctrl: fleet-level march controller for the alien formation.
// Drives the shared move_left/move_right/move_down levels, paces them with a
// frame-based step counter and raises the invasion / wave-clear indications.
// Optional feature macro: ALIEN_SPEEDUP_EN. When it is defined, the step
// period shrinks as aliens are destroyed. When it is undefined, the period is
// the constant STEP_FRAMES.
module alien_march_ctrl #(
  parameter int NUM_ALIENS      = 8,
  parameter int STEP_FRAMES     = 200,
  parameter int MIN_STEP_FRAMES = 40,
  parameter int SPEEDUP_FRAMES  = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mode,
  input  logic [9:0]            xCoord,
  input  logic [9:0]            yCoord,
  input  logic [NUM_ALIENS-1:0] is_edge,
  input  logic [NUM_ALIENS-1:0] is_bottom,
  input  logic [NUM_ALIENS-1:0] alien_alive,
  output logic                  move_left,
  output logic                  move_right,
  output logic                  move_down,
  output logic                  step_tick,
  output logic [7:0]            alive_count,
  output logic                  invaded,
  output logic                  wave_clear
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RIGHT  = 3'd1,
    ST_DOWN_R = 3'd2,
    ST_LEFT   = 3'd3,
    ST_DOWN_L = 3'd4,
    ST_OVER   = 3'd5,
    ST_CLEAR  = 3'd6
  } state_t;

  localparam logic [10:0] STEP_P = 11'(STEP_FRAMES);

  // Number of set bits in the alive vector.
  function automatic logic [7:0] popcount(input logic [NUM_ALIENS-1:0] v);
    logic [7:0] c;
    c = 8'd0;
    for (int i = 0; i < NUM_ALIENS; i++) begin
      c = c + {7'd0, v[i]};
    end
    return c;
  endfunction

  state_t      state_q, state_d;
  logic [10:0] frame_cnt_q, frame_cnt_d;
  logic        frame_raw_q, frame_raw_d;
  logic        frame_tick_q, frame_tick_d;
  logic        step_tick_q, step_tick_d;
  logic [7:0]  alive_count_q, alive_count_d;
  logic        bottom_any_q, bottom_any_d;
  logic        move_left_q, move_left_d;
  logic        move_right_q, move_right_d;
  logic        move_down_q, move_down_d;
  logic        invaded_q, invaded_d;
  logic        wave_clear_q, wave_clear_d;

  logic        frame_raw;
  logic        edge_any;
  logic        bottom_any;
  logic        marching;
  logic [10:0] period;
  logic [10:0] period_m1;

  assign frame_raw  = (xCoord == 10'd0) && (yCoord == 10'd0);
  // Dead aliens keep stale edge/bottom flags; mask them out.
  assign edge_any   = |(is_edge & alien_alive);
  assign bottom_any = |(is_bottom & alien_alive);
  assign marching   = (state_q == ST_RIGHT) || (state_q == ST_DOWN_R) ||
                      (state_q == ST_LEFT)  || (state_q == ST_DOWN_L);

`ifdef ALIEN_SPEEDUP_EN
  logic [7:0]  dead_cnt;
  logic [18:0] reduce;

  // Speed-up period: shrink per destroyed alien, saturating at the floor.
  always_comb begin
    dead_cnt = 8'(NUM_ALIENS) - alive_count_q;
    reduce   = 19'(SPEEDUP_FRAMES) * {11'd0, dead_cnt};
    if (reduce >= 19'(STEP_FRAMES - MIN_STEP_FRAMES)) begin
      period = 11'(MIN_STEP_FRAMES);
    end else begin
      period = STEP_P - reduce[10:0];
    end
  end
`else
  assign period = STEP_P;
`endif

  assign period_m1 = period - 11'd1;

  // Frame edge detection and per-clock aggregate registers.
  always_comb begin
    frame_raw_d   = frame_raw;
    frame_tick_d  = frame_raw & ~frame_raw_q;
    alive_count_d = popcount(alien_alive);
    bottom_any_d  = bottom_any;
  end

  // Next-state, step counter and registered output decodes.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    step_tick_d = 1'b0;
    case (mode)
      2'd0, 2'd1: begin
        state_d     = ST_IDLE;
        frame_cnt_d = 11'd0;
      end
      2'd3: begin
        // Paused: state and counter frozen, outputs hold via the decode.
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
      end
      default: begin
        if (state_q == ST_IDLE) begin
          state_d     = ST_RIGHT;
          frame_cnt_d = 11'd0;
        end else if (marching) begin
          if (frame_tick_q) begin
            // >= so that a period shrinking below the count wraps next tick.
            if (frame_cnt_q >= period_m1) begin
              frame_cnt_d = 11'd0;
              step_tick_d = 1'b1;
            end else begin
              frame_cnt_d = frame_cnt_q + 11'd1;
            end
          end else begin
            frame_cnt_d = frame_cnt_q;
          end
          if (alive_count_q == 8'd0) begin
            state_d = ST_CLEAR;
          end else if (bottom_any_q) begin
            state_d = ST_OVER;
          end else if (step_tick_d) begin
            case (state_q)
              ST_RIGHT:  state_d = edge_any ? ST_DOWN_R : ST_RIGHT;
              ST_DOWN_R: state_d = ST_LEFT;
              ST_LEFT:   state_d = edge_any ? ST_DOWN_L : ST_LEFT;
              ST_DOWN_L: state_d = ST_RIGHT;
              default:   state_d = state_q;
            endcase
          end else begin
            state_d = state_q;
          end
        end else begin
          // OVER / CLEAR hold while play mode persists.
          state_d = state_q;
        end
      end
    endcase

    move_right_d = (state_d == ST_RIGHT);
    move_left_d  = (state_d == ST_LEFT);
    move_down_d  = (state_d == ST_DOWN_R) || (state_d == ST_DOWN_L);
    invaded_d    = (state_d == ST_OVER);
    wave_clear_d = (state_d == ST_CLEAR);
  end

  // State, counter and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      frame_cnt_q   <= 11'd0;
      frame_raw_q   <= 1'b0;
      frame_tick_q  <= 1'b0;
      step_tick_q   <= 1'b0;
      alive_count_q <= 8'd0;
      bottom_any_q  <= 1'b0;
      move_left_q   <= 1'b0;
      move_right_q  <= 1'b0;
      move_down_q   <= 1'b0;
      invaded_q     <= 1'b0;
      wave_clear_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_cnt_q   <= frame_cnt_d;
      frame_raw_q   <= frame_raw_d;
      frame_tick_q  <= frame_tick_d;
      step_tick_q   <= step_tick_d;
      alive_count_q <= alive_count_d;
      bottom_any_q  <= bottom_any_d;
      move_left_q   <= move_left_d;
      move_right_q  <= move_right_d;
      move_down_q   <= move_down_d;
      invaded_q     <= invaded_d;
      wave_clear_q  <= wave_clear_d;
    end
  end

  assign move_left   = move_left_q;
  assign move_right  = move_right_q;
  assign move_down   = move_down_q;
  assign step_tick   = step_tick_q;
  assign alive_count = alive_count_q;
  assign invaded     = invaded_q;
  assign wave_clear  = wave_clear_q;

endmodule

// File: tb/tb_alien_march_ctrl.sv
// Self-checking bench for alien_march_ctrl: directed steps, expectations queued
// on a scoreboard when stimulus is applied and popped when outputs are sampled.
module tb_alien_march_ctrl;

  logic       clk;
  logic       rst;
  logic [1:0] mode;
  logic [9:0] xCoord;
  logic [9:0] yCoord;
  logic [7:0] is_edge;
  logic [7:0] is_bottom;
  logic [7:0] alien_alive;
  logic       move_left;
  logic       move_right;
  logic       move_down;
  logic       step_tick;
  logic [7:0] alive_count;
  logic       invaded;
  logic       wave_clear;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  // Output vector bits: {invaded, wave_clear, move_down, move_left, move_right}
  localparam logic [31:0] O_NONE  = 32'h00;
  localparam logic [31:0] O_RIGHT = 32'h01;
  localparam logic [31:0] O_LEFT  = 32'h02;
  localparam logic [31:0] O_DOWN  = 32'h04;
  localparam logic [31:0] O_CLEAR = 32'h08;
  localparam logic [31:0] O_OVER  = 32'h10;

  alien_march_ctrl dut (
    .clk(clk), .rst(rst), .mode(mode), .xCoord(xCoord), .yCoord(yCoord),
    .is_edge(is_edge), .is_bottom(is_bottom), .alien_alive(alien_alive),
    .move_left(move_left), .move_right(move_right), .move_down(move_down),
    .step_tick(step_tick), .alive_count(alive_count), .invaded(invaded),
    .wave_clear(wave_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] outv();
    return {27'd0, invaded, wave_clear, move_down, move_left, move_right};
  endfunction

  // Reference step period for a given number of live aliens.
  function automatic int exp_period(input int alive);
    int p;
`ifdef ALIEN_SPEEDUP_EN
    p = 200 - 20 * (8 - alive);
    if (p < 40) p = 40;
`else
    p = 200 + 0 * alive;
`endif
    return p;
  endfunction

  task automatic push_exp(input string t, input logic [31:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed=%0d expected=<none>", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed=%0d expected=%0d", t, obs, e);
      end
    end
  endtask

  // One video frame: pixel (0,0) for one clock, then elsewhere; report step_tick.
  task automatic do_frame(output bit seen);
    @(negedge clk);
    xCoord = 10'd0;
    yCoord = 10'd0;
    @(negedge clk);
    xCoord = 10'd5;
    @(negedge clk);
    seen = step_tick;
  endtask

  task automatic run_frames(input int k, output int steps);
    bit s;
    steps = 0;
    for (int i = 0; i < k; i++) begin
      do_frame(s);
      if (s) steps++;
    end
  endtask

  // Frames until the first step_tick, bounded; -1 if the bound expires.
  task automatic run_until_step(input int max_frames, output int n);
    bit s;
    bit done;
    n    = -1;
    done = 1'b0;
    for (int i = 1; i <= max_frames && !done; i++) begin
      do_frame(s);
      if (s) begin
        n    = i;
        done = 1'b1;
      end
    end
  endtask

  task automatic wait_clks(input int k);
    for (int i = 0; i < k; i++) @(negedge clk);
  endtask

  initial begin
    int n;
    int st;
    rst         = 1'b0;
    mode        = 2'd2;
    xCoord      = 10'd5;
    yCoord      = 10'd0;
    is_edge     = 8'h00;
    is_bottom   = 8'h00;
    alien_alive = 8'hFF;

    // Reset state
    push_exp("reset_outputs", O_NONE);
    push_exp("reset_alive_count", 32'd0);
    push_exp("reset_step_tick", 32'd0);
    wait_clks(3);
    pop_check(outv());
    pop_check({24'd0, alive_count});
    pop_check({31'd0, step_tick});

    // Release with mode=2: marching right within 2 clk
    rst = 1'b1;
    push_exp("start_move_right", O_RIGHT);
    push_exp("start_alive_count", 32'd8);
    wait_clks(2);
    pop_check(outv());
    pop_check({24'd0, alive_count});

    // First step after exactly 200 frames, still marching right
    push_exp("first_step_frames", 32'd200);
    push_exp("first_step_right", O_RIGHT);
    run_until_step(300, n);
    pop_check(32'(n));
    pop_check(outv());

    // Live alien 3 at edge: descent, held for a full step, then left
    is_edge = 8'h08;
    push_exp("edge3_step_frames", 32'd200);
    push_exp("edge3_move_down", O_DOWN);
    run_until_step(300, n);
    pop_check(32'(n));
    pop_check(outv());
    is_edge = 8'h00;
    push_exp("down_mid_no_step", 32'd0);
    push_exp("down_mid_level", O_DOWN);
    run_frames(100, st);
    pop_check(32'(st));
    pop_check(outv());
    push_exp("down_rest_frames", 32'd100);
    push_exp("after_down_left", O_LEFT);
    run_until_step(300, n);
    pop_check(32'(n));
    pop_check(outv());

    // Edge while marching left: descent into DOWN_L
    is_edge = 8'h01;
    push_exp("edge0_step_frames", 32'd200);
    push_exp("edge0_move_down", O_DOWN);
    run_until_step(300, n);
    pop_check(32'(n));
    pop_check(outv());
    is_edge = 8'h00;

    // Bottom reached in DOWN_L: invaded within 2 clk, moves off, sticky
    is_bottom = 8'h01;
    push_exp("bottom_invaded", O_OVER);
    wait_clks(2);
    pop_check(outv());
    push_exp("over_hold_no_step", 32'd0);
    push_exp("over_hold_level", O_OVER);
    run_frames(5, st);
    pop_check(32'(st));
    pop_check(outv());
    mode = 2'd0;
    push_exp("menu_clears_invaded", O_NONE);
    wait_clks(1);
    pop_check(outv());
    is_bottom = 8'h00;

    // Pause at frame_cnt=120 for 500 frames, then 80 more frames to step
    mode = 2'd2;
    push_exp("pre_pause_no_step", 32'd0);
    run_frames(120, st);
    pop_check(32'(st));
    mode = 2'd3;
    push_exp("pause_no_step", 32'd0);
    push_exp("pause_hold_right", O_RIGHT);
    run_frames(500, st);
    pop_check(32'(st));
    pop_check(outv());
    mode = 2'd2;
    push_exp("resume_step_frames", 32'd80);
    run_until_step(300, n);
    pop_check(32'(n));

    // Dead alien 5 with stale edge: no descent over 3 steps
    alien_alive = 8'hDF;
    is_edge     = 8'h20;
    for (int k = 0; k < 3; k++) begin
      push_exp("dead_edge_step_frames", 32'(exp_period(7)));
      push_exp("dead_edge_right", O_RIGHT);
      run_until_step(300, n);
      pop_check(32'(n));
      pop_check(outv());
    end
    push_exp("alive_count_7", 32'd7);
    pop_check({24'd0, alive_count});

    // Four of eight destroyed: period follows the speed-up rule
    alien_alive = 8'h0F;
    push_exp("kill4_step_frames", 32'(exp_period(4)));
    push_exp("kill4_right", O_RIGHT);
    run_until_step(300, n);
    pop_check(32'(n));
    pop_check(outv());

    // All destroyed: wave_clear within 2 clk, moves off
    alien_alive = 8'h00;
    push_exp("wave_clear", O_CLEAR);
    push_exp("alive_count_0", 32'd0);
    wait_clks(2);
    pop_check(outv());
    pop_check({24'd0, alive_count});

    // Menu clears wave_clear; restart and march
    mode = 2'd0;
    push_exp("menu_clears_wave", O_NONE);
    wait_clks(1);
    pop_check(outv());
    alien_alive = 8'hFF;
    is_edge     = 8'h00;
    mode        = 2'd2;
    push_exp("restart_no_step", 32'd0);
    push_exp("restart_right", O_RIGHT);
    run_frames(50, st);
    pop_check(32'(st));
    pop_check(outv());

    // Asynchronous reset mid-step forces outputs low immediately
    #2;
    rst = 1'b0;
    #1;
    push_exp("async_reset_outputs", O_NONE);
    push_exp("async_reset_alive", 32'd0);
    pop_check(outv());
    pop_check({24'd0, alive_count});
    mode = 2'd0;
    @(negedge clk);
    rst = 1'b1;
    push_exp("idle_after_reset", O_NONE);
    wait_clks(4);
    pop_check(outv());
    mode = 2'd2;
    push_exp("idle_to_right", O_RIGHT);
    wait_clks(2);
    pop_check(outv());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alien_march_ctrl.md
# alien_march_ctrl

Fleet-level march controller for the alien formation. It sits directly upstream of the per-alien blocks and drives their shared `move_left` / `move_right` / `move_down` levels. It reacts to their aggregated `is_edge` / `is_bottom` flags and their alive status. It also raises the invasion (game-over) and wave-clear indications consumed by the game-mode logic.

## Interface
Parameters:
- `NUM_ALIENS`, 8: number of alien instances aggregated.
- `STEP_FRAMES`, 200: frames per march step; matches the per-alien move period.
- `MIN_STEP_FRAMES`, 40: floor on the step period (speed-up only).
- `SPEEDUP_FRAMES`, 20: period reduction per destroyed alien (speed-up only).

Ports:
- `clk`, in, 1: system clock; the block's single clock.
- `rst`, in, 1: asynchronous, active-low reset.
- `mode`, in, 2: game mode; 0/1 = menu, 2 = play, 3 = pause.
- `xCoord`, in, 10: current VGA pixel x.
- `yCoord`, in, 10: current VGA pixel y.
- `is_edge`, in, NUM_ALIENS: per-alien edge flags.
- `is_bottom`, in, NUM_ALIENS: per-alien bottom flags.
- `alien_alive`, in, NUM_ALIENS: 1 = alien not destroyed.
- `move_left`, out, 1: registered level to all aliens.
- `move_right`, out, 1: registered level to all aliens.
- `move_down`, out, 1: registered level to all aliens.
- `step_tick`, out, 1: one-cycle pulse at each step boundary.
- `alive_count`, out, 8: registered popcount of `alien_alive`.
- `invaded`, out, 1: sticky game-over flag.
- `wave_clear`, out, 1: sticky all-destroyed flag.

## Operation
- **Frame tick:** `frame_raw = (xCoord==0 && yCoord==0)`. `frame_tick` is the rising edge of `frame_raw`, detected against a registered copy, so it is exactly one clk per frame.
- **Step counter:** `frame_cnt` (11 bits) advances only on `frame_tick` in the RIGHT/DOWN_R/LEFT/DOWN_L states.
  - On a tick with `frame_cnt == period-1`: `frame_cnt <= 0` and `step_tick` pulses on the next clk.
  - Otherwise `frame_cnt` increments.
- **Period:** `period = STEP_FRAMES`, except with speed-up (see Configuration).
- **Aggregates:**
  - `edge_any = |(is_edge & alien_alive)`
  - `bottom_any = |(is_bottom & alien_alive)`
  - `alive_count` is the popcount of `alien_alive`, registered every clk.
- **FSM states:** IDLE, RIGHT, DOWN_R, LEFT, DOWN_L, OVER, CLEAR.
  - IDLE: mode==2 → RIGHT, with `frame_cnt` cleared.
  - RIGHT: on `step_tick`, `edge_any` → DOWN_R.
  - DOWN_R: on `step_tick` → LEFT.
  - LEFT: on `step_tick`, `edge_any` → DOWN_L.
  - DOWN_L: on `step_tick` → RIGHT.
  - Any marching state: `bottom_any` → OVER.
  - Any marching state: `alive_count == 0` → CLEAR.
  - OVER and CLEAR hold until mode≠2.
  - Any state with mode 0/1 → IDLE: counter cleared, `invaded` and `wave_clear` cleared.
  - mode 3: state and `frame_cnt` frozen; outputs hold.
- **Transition priority:** mode 0/1 > CLEAR > OVER > edge/step transitions. CLEAR beats OVER when the last alien dies on the bottom row in the same cycle.
- **Outputs:** registered decodes of the next state.
  - `move_right = (RIGHT)`, `move_left = (LEFT)`, `move_down = (DOWN_R|DOWN_L)`.
  - At most one of the three is high, and each is stable for a full step period.
  - `invaded` = 1 in OVER; `wave_clear` = 1 in CLEAR.
- **Edge filter:** dead aliens are ignored. A destroyed alien's stale `is_edge` never triggers a descent.

## Timing
- **Reset values:** state IDLE, `frame_cnt` 0, and every output 0 (`move_*`, `step_tick`, `invaded`, `wave_clear`, `alive_count`).
- **Latencies:**
  - `frame_raw` rise → `frame_tick`: 1 clk.
  - Final tick of a period → `step_tick`: 1 clk.
  - `step_tick` → new `move_*` level: same edge as `step_tick` assertion (state and outputs update together).
  - `bottom_any` or `alive_count==0` → `invaded` / `wave_clear`: 2 clk (popcount register, then state).
- **Simultaneous events:** when `edge_any` and `step_tick` coincide in RIGHT, exactly one DOWN step occurs; no horizontal step is issued on that boundary.
- **Mid-operation reset:** reset asserted mid-step asynchronously forces all outputs to 0. On release, the block waits in IDLE for mode 2.
- **Wrap-around:** `frame_cnt` never exceeds period-1. If the period shrinks below the current count, the counter wraps on the next tick.

## Configuration
- Macro: `ALIEN_SPEEDUP_EN`.
- **Defined:** `period = max(MIN_STEP_FRAMES, STEP_FRAMES − SPEEDUP_FRAMES × (NUM_ALIENS − alive_count))`, computed in 11 bits with the subtraction saturating at `MIN_STEP_FRAMES`.
- **Undefined:** `period = STEP_FRAMES` constant; no speed-up logic is synthesized.

## Test plan
- Reset low, then released with mode=2 → move_right=1 within 2 clk; step_tick every 200 frame ticks.
- In RIGHT, alien 3 `is_edge=1` and alive → next step_tick gives move_down=1 for 200 frames, then move_left=1.
- Alien 5 `is_edge=1` but `alien_alive[5]=0` → no descent; move_right stays 1 across 3 step_ticks.
- `is_bottom[0]=1` and alive in DOWN_L → invaded=1 within 2 clk and move_* all 0; mode→0 clears it.
- mode=3 at frame_cnt=120 for 500 frames, then mode=2 → next step_tick after exactly 80 more frames.
- With `ALIEN_SPEEDUP_EN`, kill 4 of 8 aliens → period 120; kill 8 → wave_clear=1 and move_* 0.
